// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: load-use, branch redirect,
// data-memory wait with timeout, saturating perf counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             idex_mem_read_i,
  input  logic [4:0]       idex_rd_i,
  input  logic [4:0]       ifid_rn_i,
  input  logic [4:0]       ifid_rm_i,
  input  logic             ifid_uses_rm_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             pc_we_o,
  output logic             ifid_we_o,
  output logic             idex_we_o,
  output logic             exmem_we_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             exmem_flush_o,
  output logic             memwb_flush_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             load_use;
  logic             flush_ev;

  // X31 reads as zero, so it never carries a real dependency
  assign load_use = idex_mem_read_i && (idex_rd_i != 5'd31) &&
                    ((idex_rd_i == ifid_rn_i) ||
                     (ifid_uses_rm_i && (idex_rd_i == ifid_rm_i)));

  // Mealy control: next state and enables/flushes
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    mem_err_d     = mem_err_q;
    flush_ev      = 1'b0;
    pc_we_o       = 1'b1;
    ifid_we_o     = 1'b1;
    idex_we_o     = 1'b1;
    exmem_we_o    = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_flush_o = 1'b0;
    memwb_flush_o = 1'b0;
    if (rst_i) begin
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
      exmem_flush_o = 1'b1;
      memwb_flush_o = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (branch_taken_i) begin
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            exmem_flush_o = 1'b1;
            flush_ev      = 1'b1;
          end else if (dmem_req_i && !dmem_ready_i) begin
            pc_we_o       = 1'b0;
            ifid_we_o     = 1'b0;
            idex_we_o     = 1'b0;
            exmem_we_o    = 1'b0;
            memwb_flush_o = 1'b1;
            state_d       = MEM_WAIT;
            wait_d        = WW'(1);
          end else if (load_use) begin
            pc_we_o      = 1'b0;
            ifid_we_o    = 1'b0;
            idex_flush_o = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready_i) begin
            state_d = RUN;
            wait_d  = '0;
            if (load_use) begin
              pc_we_o      = 1'b0;
              ifid_we_o    = 1'b0;
              idex_flush_o = 1'b1;
            end
          end else begin
            pc_we_o       = 1'b0;
            ifid_we_o     = 1'b0;
            idex_we_o     = 1'b0;
            exmem_we_o    = 1'b0;
            memwb_flush_o = 1'b1;
            if (wait_q == WW'(MEM_TIMEOUT)) begin
              state_d   = ERROR;
              mem_err_d = 1'b1;
            end else begin
              wait_d = wait_q + WW'(1);
            end
          end
        end
        default: begin
          pc_we_o       = 1'b0;
          ifid_we_o     = 1'b0;
          idex_we_o     = 1'b0;
          exmem_we_o    = 1'b0;
          ifid_flush_o  = 1'b1;
          idex_flush_o  = 1'b1;
          exmem_flush_o = 1'b1;
          memwb_flush_o = 1'b1;
        end
      endcase
    end
  end

  // Saturating counters: stop at all-ones instead of wrapping
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!rst_i && !pc_we_o && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if (flush_ev && (flush_q != '1)) begin
      flush_d = flush_q + CNT_W'(1);
    end
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  assign mem_err_o   = mem_err_q;
  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl.
// Expected entries are queued at drive time and popped at sample time.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mr;
  logic [4:0]  rd, rn, rm;
  logic        urm, br, req, rdy;

  logic        pc_we, ifid_we, idex_we, exmem_we;
  logic        f_ifid, f_idex, f_exmem, f_memwb;
  logic        err;
  logic [15:0] scnt, fcnt;

  logic        pc_we4, ifid_we4, idex_we4, exmem_we4;
  logic        f_ifid4, f_idex4, f_exmem4, f_memwb4;
  logic        err4;
  logic [3:0]  scnt4, fcnt4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] ctrl;
    int         stall;
    int         flush;
    logic       err;
  } exp_t;

  exp_t sb[$];

  localparam logic [7:0] C_RUN = 8'b1111_0000;
  localparam logic [7:0] C_LU  = 8'b0011_0100;
  localparam logic [7:0] C_BR  = 8'b1111_1110;
  localparam logic [7:0] C_WT  = 8'b0000_0001;
  localparam logic [7:0] C_ERR = 8'b0000_1111;
  localparam logic [7:0] C_RST = 8'b1111_1111;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .idex_mem_read_i(mr), .idex_rd_i(rd),
    .ifid_rn_i(rn), .ifid_rm_i(rm),
    .ifid_uses_rm_i(urm), .branch_taken_i(br),
    .dmem_req_i(req), .dmem_ready_i(rdy),
    .pc_we_o(pc_we), .ifid_we_o(ifid_we),
    .idex_we_o(idex_we), .exmem_we_o(exmem_we),
    .ifid_flush_o(f_ifid), .idex_flush_o(f_idex),
    .exmem_flush_o(f_exmem), .memwb_flush_o(f_memwb),
    .mem_err_o(err), .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
  );

  pipe_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst),
    .idex_mem_read_i(mr), .idex_rd_i(rd),
    .ifid_rn_i(rn), .ifid_rm_i(rm),
    .ifid_uses_rm_i(urm), .branch_taken_i(br),
    .dmem_req_i(req), .dmem_ready_i(rdy),
    .pc_we_o(pc_we4), .ifid_we_o(ifid_we4),
    .idex_we_o(idex_we4), .exmem_we_o(exmem_we4),
    .ifid_flush_o(f_ifid4), .idex_flush_o(f_idex4),
    .exmem_flush_o(f_exmem4), .memwb_flush_o(f_memwb4),
    .mem_err_o(err4), .stall_cnt_o(scnt4), .flush_cnt_o(fcnt4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, queue expectation, check before posedge.
  // Counter/err expectations are the values before this cycle's edge.
  task automatic step(input string tag,
                      input logic r, input logic m,
                      input logic [4:0] d, input logic [4:0] n,
                      input logic [4:0] mm, input logic u,
                      input logic b, input logic q, input logic y,
                      input logic [7:0] ec, input int es,
                      input int ef, input logic ee);
    exp_t e, g;
    @(negedge clk);
    rst = r; mr = m; rd = d; rn = n; rm = mm;
    urm = u; br = b; req = q; rdy = y;
    e.ctrl = ec; e.stall = es; e.flush = ef; e.err = ee;
    sb.push_back(e);
    #2;
    g = sb.pop_front();
    chk({tag, ".ctrl"}, {24'd0, pc_we, ifid_we, idex_we, exmem_we,
                         f_ifid, f_idex, f_exmem, f_memwb},
        {24'd0, g.ctrl});
    chk({tag, ".stall"}, {16'd0, scnt}, g.stall);
    chk({tag, ".flush"}, {16'd0, fcnt}, g.flush);
    chk({tag, ".err"}, {31'd0, err}, {31'd0, g.err});
  endtask

  task automatic idle(input string tag, input logic [7:0] ec,
                      input int es, input int ef, input logic ee);
    step(tag, 0, 0, 0, 1, 2, 0, 0, 0, 0, ec, es, ef, ee);
  endtask

  task automatic lu(input string tag, input logic [7:0] ec,
                    input int es, input int ef);
    step(tag, 0, 1, 5, 5, 0, 0, 0, 0, 0, ec, es, ef, 0);
  endtask

  task automatic mwait(input string tag, input logic y,
                       input logic [7:0] ec, input int es);
    step(tag, 0, 0, 0, 1, 2, 0, 0, 1, y, ec, es, 1, 0);
  endtask

  initial begin
    rst = 1; mr = 0; rd = 0; rn = 0; rm = 0;
    urm = 0; br = 0; req = 0; rdy = 0;

    step("rst", 1, 0, 0, 1, 2, 0, 0, 0, 0, C_RST, 0, 0, 0);
    idle("run0", C_RUN, 0, 0, 0);

    lu("lu", C_LU, 0, 0);
    idle("lu_after", C_RUN, 1, 0, 0);
    step("xzr", 0, 1, 31, 31, 31, 1, 0, 0, 0, C_RUN, 1, 0, 0);
    step("rm_off", 0, 1, 7, 0, 7, 0, 0, 0, 0, C_RUN, 1, 0, 0);
    step("rm_on", 0, 1, 7, 0, 7, 1, 0, 0, 0, C_LU, 1, 0, 0);

    step("br_lu", 0, 1, 5, 5, 0, 0, 1, 0, 0, C_BR, 2, 0, 0);
    idle("br_after", C_RUN, 2, 1, 0);

    mwait("mw_run", 0, C_WT, 2);
    mwait("mw_w1", 0, C_WT, 3);
    step("mw_w2_br", 0, 0, 0, 1, 2, 0, 1, 1, 0, C_WT, 4, 1, 0);
    mwait("mw_rdy", 1, C_RUN, 5);
    idle("mw_after", C_RUN, 5, 1, 0);

    mwait("mw2_run", 0, C_WT, 5);
    step("mw2_rdy_lu", 0, 1, 5, 5, 0, 0, 0, 1, 1, C_LU, 6, 1, 0);
    idle("mw2_after", C_RUN, 7, 1, 0);

    mwait("to_run", 0, C_WT, 7);
    for (int i = 1; i <= 15; i++) begin
      mwait($sformatf("to_w%0d", i), 0, C_WT, 7 + i);
    end
    step("err0", 0, 0, 0, 1, 2, 0, 1, 1, 1, C_ERR, 23, 1, 1);
    idle("err1", C_ERR, 24, 1, 1);

    step("rst2", 1, 0, 0, 1, 2, 0, 0, 0, 0, C_RST, 25, 1, 1);
    idle("post_rst", C_RUN, 0, 0, 0);
    lu("post_lu", C_LU, 0, 0);

    step("rst3", 1, 0, 0, 1, 2, 0, 0, 0, 0, C_RST, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      lu($sformatf("sat%0d", i), C_LU, i, 0);
      chk($sformatf("sat4_%0d", i), {28'd0, scnt4},
          (i > 15) ? 15 : i);
    end
    idle("sat_end", C_RUN, 20, 0, 0);
    chk("sat4_end", {28'd0, scnt4}, 15);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
